// File: rtl/step_ram_pkg.sv
// rtl/step_ram_pkg.sv - shared constants and helpers for the step_dpram memory
//
// Purpose: byte-lane sizing, read latency as a function of the output-register
// option, and the elaboration-time parameter sanity check.
package step_ram_pkg;

  localparam int BYTE_W = 8;

  // Number of byte lanes for a given data width.
  function automatic int be_w(input int data_w);
    return data_w / BYTE_W;
  endfunction

  // Cycles from the accepting edge to the readdatavalid pulse.
  function automatic int read_latency(input int out_reg);
    return (out_reg != 0) ? 2 : 1;
  endfunction

  // Data width must be whole bytes and the array must fit the address space.
  function automatic bit params_ok(input int data_w, input longint depth, input int addr_w);
    return ((data_w % BYTE_W) == 0) && (depth >= 1) && (depth <= (longint'(1) << addr_w));
  endfunction

endpackage

// File: rtl/step_dpram_if.sv
// rtl/step_dpram_if.sv - Avalon-MM style slave port bundle for step_dpram
//
// Purpose: groups one memory port's request and response signals.
// Signals: address/chipselect/read/write/byteenable/writedata (master -> slave),
//          readdata/readdatavalid (slave -> master).
interface step_dpram_if
  import step_ram_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16
);
  localparam int BE_W = be_w(DATA_W);

  logic [ADDR_W-1:0] address;
  logic              chipselect;
  logic              read;
  logic              write;
  logic [BE_W-1:0]   byteenable;
  logic [DATA_W-1:0] writedata;
  logic [DATA_W-1:0] readdata;
  logic              readdatavalid;

  modport master (
    output address, chipselect, read, write, byteenable, writedata,
    input  readdata, readdatavalid
  );

  modport slave (
    input  address, chipselect, read, write, byteenable, writedata,
    output readdata, readdatavalid
  );

endinterface

// File: rtl/step_ram_port.sv
// rtl/step_ram_port.sv - request decode and read-valid pipeline for one port
//
// Purpose: qualifies a port's request against stall and address range, and
// carries a valid bit plus an out-of-range (zero-data) flag down the read
// pipeline so the top can mask data for reads beyond DEPTH.
// Ports:
//   clk, reset      clock, async active-high reset
//   i_stall         block-wide stall (clock enable low or reset request)
//   i_address/i_chipselect/i_read/i_write  raw request
//   o_wr_en         accepted in-range write
//   o_rd_en         accepted in-range read (capture array output)
//   o_valid         readdatavalid for this port
//   o_zero          final-stage read was out of range; data must read as zero
module step_ram_port
  import step_ram_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DEPTH   = 51200,
  parameter int OUT_REG = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_stall,
  input  logic [ADDR_W-1:0] i_address,
  input  logic              i_chipselect,
  input  logic              i_read,
  input  logic              i_write,
  output logic              o_wr_en,
  output logic              o_rd_en,
  output logic              o_valid,
  output logic              o_zero
);

  localparam int                LAT     = read_latency(OUT_REG);
  localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W + 1)'(DEPTH);

  logic           w_accept;
  logic           w_in_range;
  logic           w_rd;
  logic [LAT-1:0] r_v;
  logic [LAT-1:0] r_z;

  assign w_accept   = i_chipselect & ~i_stall;
  assign w_in_range = ({1'b0, i_address} < DEPTH_L);
  // A simultaneous write wins; the read is dropped and never pulses valid.
  assign w_rd       = w_accept & i_read & ~i_write;

  assign o_wr_en = w_accept & i_write & w_in_range;
  assign o_rd_en = w_rd & w_in_range;

  // Pipeline only advances when not stalled, so in-flight reads freeze in place.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_v <= '0;
      r_z <= '0;
    end else if (!i_stall) begin
      r_v[0] <= w_rd;
      r_z[0] <= ~w_in_range;
      for (int i = 1; i < LAT; i++) begin
        r_v[i] <= r_v[i-1];
        r_z[i] <= r_z[i-1];
      end
    end
  end

  assign o_valid = r_v[LAT-1] & ~i_stall;
  assign o_zero  = r_z[LAT-1];

endmodule

// File: rtl/step_dpram.sv
// rtl/step_dpram.sv - parametrised true-dual-port RAM with pipelined reads
//
// Purpose: shared program/data memory with two independent slave ports on one
// clock, byte-lane writes, s1 priority on same-address write collisions,
// read-before-write across ports, optional output register.
// Ports:
//   clk, reset   clock, async active-high reset (array contents are kept)
//   reset_req    high: stall the whole block
//   clken        low: stall the whole block
//   s1, s2       slave ports (step_dpram_if.slave)
module step_dpram
  import step_ram_pkg::*;
#(
  parameter int    DATA_W    = 32,
  parameter int    ADDR_W    = 16,
  parameter int    DEPTH     = 51200,
  parameter int    OUT_REG   = 0,
  parameter string INIT_FILE = "step_RAM.hex"
) (
  input  logic clk,
  input  logic reset,
  input  logic reset_req,
  input  logic clken,
  step_dpram_if.slave s1,
  step_dpram_if.slave s2
);

  localparam int BE_W  = be_w(DATA_W);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // The power-up image is attached to the array by the FPGA flow through the
  // ram_init_file attribute, so an empty name would leave memory undefined.
  if (!params_ok(DATA_W, DEPTH, ADDR_W) || (INIT_FILE == "")) begin : g_bad_params
    $error("step_dpram: need DATA_W%%8==0, 1<=DEPTH<=2**ADDR_W and a non-empty INIT_FILE");
  end

  logic              w_stall;
  logic              w_wr1, w_rd1, w_v1, w_z1;
  logic              w_wr2, w_rd2, w_v2, w_z2;
  logic [IDX_W-1:0]  w_idx1, w_idx2;
  logic [DATA_W-1:0] w_d1, w_d2;
  logic [DATA_W-1:0] r_q1, r_q2;

  (* ram_init_file = INIT_FILE *) logic [DATA_W-1:0] r_mem [0:DEPTH-1];

  assign w_stall = ~clken | reset_req;
  assign w_idx1  = s1.address[IDX_W-1:0];
  assign w_idx2  = s2.address[IDX_W-1:0];

  step_ram_port #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .OUT_REG(OUT_REG)) u_port1 (
    .clk(clk), .reset(reset), .i_stall(w_stall),
    .i_address(s1.address), .i_chipselect(s1.chipselect),
    .i_read(s1.read), .i_write(s1.write),
    .o_wr_en(w_wr1), .o_rd_en(w_rd1), .o_valid(w_v1), .o_zero(w_z1)
  );

  step_ram_port #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .OUT_REG(OUT_REG)) u_port2 (
    .clk(clk), .reset(reset), .i_stall(w_stall),
    .i_address(s2.address), .i_chipselect(s2.chipselect),
    .i_read(s2.read), .i_write(s2.write),
    .o_wr_en(w_wr2), .o_rd_en(w_rd2), .o_valid(w_v2), .o_zero(w_z2)
  );

  // s2 lanes are scheduled first so that any lane s1 also enables on the same
  // word is overwritten by s1's later non-blocking update.
  always_ff @(posedge clk) begin
    if (w_wr2) begin
      for (int i = 0; i < BE_W; i++) begin
        if (s2.byteenable[i]) r_mem[w_idx2][i*8 +: 8] <= s2.writedata[i*8 +: 8];
      end
    end
    if (w_wr1) begin
      for (int i = 0; i < BE_W; i++) begin
        if (s1.byteenable[i]) r_mem[w_idx1][i*8 +: 8] <= s1.writedata[i*8 +: 8];
      end
    end
  end

  // Array read registers sample the pre-write contents (read-before-write).
  always_ff @(posedge clk) begin
    if (w_rd1) r_q1 <= r_mem[w_idx1];
    if (w_rd2) r_q2 <= r_mem[w_idx2];
  end

  if (OUT_REG != 0) begin : g_oreg
    logic [DATA_W-1:0] r_o1, r_o2;
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_o1 <= '0;
        r_o2 <= '0;
      end else if (!w_stall) begin
        r_o1 <= r_q1;
        r_o2 <= r_q2;
      end
    end
    assign w_d1 = r_o1;
    assign w_d2 = r_o2;
  end else begin : g_noreg
    assign w_d1 = r_q1;
    assign w_d2 = r_q2;
  end

  // Data is forced to zero outside a valid pulse (covers reset) and for
  // out-of-range reads, whose array register was never loaded.
  assign s1.readdatavalid = w_v1;
  assign s2.readdatavalid = w_v2;
  assign s1.readdata      = (w_v1 && !w_z1) ? w_d1 : '0;
  assign s2.readdata      = (w_v2 && !w_z2) ? w_d2 : '0;

endmodule

// File: tb/tb_step_dpram.sv
// tb/tb_step_dpram.sv - scoreboard bench for step_dpram (latency 1 and 2 instances)
module tb_step_dpram;

  localparam int DEPTH = 64;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic reset_req = 1'b0;
  logic clken = 1'b1;

  always #5 clk = ~clk;

  logic [15:0] s_addr [2];
  logic        s_cs   [2];
  logic        s_rd   [2];
  logic        s_wr   [2];
  logic [3:0]  s_be   [2];
  logic [31:0] s_wd   [2];

  step_dpram_if #(.DATA_W(32), .ADDR_W(16)) ia1 ();
  step_dpram_if #(.DATA_W(32), .ADDR_W(16)) ia2 ();
  step_dpram_if #(.DATA_W(32), .ADDR_W(16)) ib1 ();
  step_dpram_if #(.DATA_W(32), .ADDR_W(16)) ib2 ();

  assign ia1.address = s_addr[0]; assign ia1.chipselect = s_cs[0]; assign ia1.read = s_rd[0];
  assign ia1.write = s_wr[0]; assign ia1.byteenable = s_be[0]; assign ia1.writedata = s_wd[0];
  assign ib1.address = s_addr[0]; assign ib1.chipselect = s_cs[0]; assign ib1.read = s_rd[0];
  assign ib1.write = s_wr[0]; assign ib1.byteenable = s_be[0]; assign ib1.writedata = s_wd[0];
  assign ia2.address = s_addr[1]; assign ia2.chipselect = s_cs[1]; assign ia2.read = s_rd[1];
  assign ia2.write = s_wr[1]; assign ia2.byteenable = s_be[1]; assign ia2.writedata = s_wd[1];
  assign ib2.address = s_addr[1]; assign ib2.chipselect = s_cs[1]; assign ib2.read = s_rd[1];
  assign ib2.write = s_wr[1]; assign ib2.byteenable = s_be[1]; assign ib2.writedata = s_wd[1];

  step_dpram #(.DATA_W(32), .ADDR_W(16), .DEPTH(DEPTH), .OUT_REG(0)) u_a (
    .clk(clk), .reset(reset), .reset_req(reset_req), .clken(clken), .s1(ia1), .s2(ia2)
  );
  step_dpram #(.DATA_W(32), .ADDR_W(16), .DEPTH(DEPTH), .OUT_REG(1)) u_b (
    .clk(clk), .reset(reset), .reset_req(reset_req), .clken(clken), .s1(ib1), .s2(ib2)
  );

  typedef struct {
    logic [31:0] d;
    int          due;
  } exp_t;

  // Channels: 0 = a.s1, 1 = a.s2, 2 = b.s1, 3 = b.s2
  exp_t q [4][$];
  int acyc  = 0;   // count of non-stalled cycles
  int tests = 0;
  int fails = 0;

  function automatic logic [31:0] pat(input int i);
    return 32'hA5000000 + 32'(i) * 32'h00010203;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  task automatic mon(input int ch, input logic v, input logic [31:0] d, input string nm);
    exp_t e;
    if (v) begin
      if (q[ch].size() == 0) begin
        tests++; fails++;
        $display("FAIL %s unexpected valid: got data %h at cycle %0d, required no pulse", nm, d, acyc);
      end else begin
        e = q[ch].pop_front();
        chk({nm, " data"}, d, e.d);
        chk({nm, " latency"}, 32'(acyc), 32'(e.due));
      end
    end else if (q[ch].size() != 0 && q[ch][0].due <= acyc) begin
      tests++; fails++;
      $display("FAIL %s missing pulse: got none at cycle %0d, required data %h", nm, acyc, q[ch][0].d);
      void'(q[ch].pop_front());
    end
  endtask

  always @(negedge clk) begin
    if (clken && !reset_req) acyc++;
    mon(0, ia1.readdatavalid, ia1.readdata, "a.s1");
    mon(1, ia2.readdatavalid, ia2.readdata, "a.s2");
    mon(2, ib1.readdatavalid, ib1.readdata, "b.s1");
    mon(3, ib2.readdatavalid, ib2.readdata, "b.s2");
  end

  // Read issued in the current (active) cycle: pulse due L active cycles later.
  task automatic push(input int p, input logic [31:0] d);
    q[p].push_back('{d: d, due: acyc + 2});
    q[p+2].push_back('{d: d, due: acyc + 3});
  endtask

  task automatic rd(input int p, input int addr, input logic [31:0] exp);
    s_cs[p] = 1'b1; s_rd[p] = 1'b1; s_wr[p] = 1'b0; s_addr[p] = 16'(addr);
    push(p, exp);
  endtask

  task automatic wr(input int p, input int addr, input logic [3:0] be, input logic [31:0] d);
    s_cs[p] = 1'b1; s_rd[p] = 1'b0; s_wr[p] = 1'b1; s_addr[p] = 16'(addr);
    s_be[p] = be; s_wd[p] = d;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    for (int p = 0; p < 2; p++) begin
      s_cs[p] = 1'b0; s_rd[p] = 1'b0; s_wr[p] = 1'b0;
      s_addr[p] = '0; s_be[p] = '0; s_wd[p] = '0;
    end
  endtask

  initial begin
    for (int p = 0; p < 2; p++) begin
      s_cs[p] = 1'b0; s_rd[p] = 1'b0; s_wr[p] = 1'b0;
      s_addr[p] = '0; s_be[p] = '0; s_wd[p] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("reset a.s1 valid", 32'(ia1.readdatavalid), 32'd0);
    chk("reset a.s2 data", ia2.readdata, 32'd0);
    chk("reset b.s1 valid", 32'(ib1.readdatavalid), 32'd0);
    chk("reset b.s2 data", ib2.readdata, 32'd0);
    reset = 1'b0;

    // Fill 0..15 (s1 low half, s2 high half, concurrently)
    for (int i = 0; i < 8; i++) begin
      wr(0, i, 4'hF, pat(i));
      wr(1, i + 8, 4'hF, pat(i + 8));
      cyc();
    end

    // Back-to-back reads with clken low for cycles 4-6 (an ignored request rides the stall)
    for (int k = 0; k < 19; k++) begin
      if (k >= 4 && k <= 6) begin
        clken = 1'b0;
        s_cs[0] = 1'b1; s_rd[0] = 1'b1; s_addr[0] = 16'd3;
      end else begin
        clken = 1'b1;
        rd(0, (k < 4) ? k : k - 3, pat((k < 4) ? k : k - 3));
        rd(1, 15 - ((k < 4) ? k : k - 3), pat(15 - ((k < 4) ? k : k - 3)));
      end
      cyc();
    end
    clken = 1'b1;

    // Byte-lane partial write
    wr(0, 5, 4'hF, 32'hDEADBEEF); cyc();
    wr(0, 5, 4'h1, 32'h000000AA); cyc();
    rd(0, 5, 32'hDEADBEAA); cyc();

    // Same-cycle writes, s1 priority
    wr(0, 7, 4'hF, 32'h11111111); wr(1, 7, 4'hF, 32'h22222222); cyc();
    rd(1, 7, 32'h11111111); cyc();
    wr(0, 7, 4'h3, 32'h11111111); wr(1, 7, 4'hF, 32'h22222222); cyc();
    rd(0, 7, 32'h22221111); cyc();

    // Cross-port read-before-write
    wr(0, 9, 4'hF, 32'h5); cyc();
    wr(0, 9, 4'hF, 32'h6); rd(1, 9, 32'h5); cyc();
    rd(1, 9, 32'h6); cyc();

    // Out of range: write at DEPTH ignored, read beyond DEPTH returns zero; top word in range
    wr(1, DEPTH, 4'hF, 32'hFFFFFFFF); cyc();
    rd(0, 0, pat(0)); rd(1, DEPTH + 3, 32'h0); cyc();
    wr(0, DEPTH - 1, 4'hF, 32'h63636363); cyc();
    rd(1, DEPTH - 1, 32'h63636363); rd(0, 3, pat(3)); cyc();

    // Read and write together on one port: write only, no pulse
    s_cs[0] = 1'b1; s_rd[0] = 1'b1; s_wr[0] = 1'b1; s_addr[0] = 16'd10;
    s_be[0] = 4'hF; s_wd[0] = 32'h0A0A0A0A; cyc();
    rd(0, 10, 32'h0A0A0A0A); cyc();

    // reset_req stalls: in-flight read held, presented write ignored
    rd(1, 4, pat(4)); cyc();
    reset_req = 1'b1; wr(0, 3, 4'hF, 32'hBADBAD00); cyc();
    reset_req = 1'b0; rd(0, 3, pat(3)); cyc();
    repeat (4) cyc();

    // Reset with two reads in flight on the latency-2 instance
    rd(0, 1, pat(1)); rd(1, 2, pat(2)); cyc();
    rd(0, 2, pat(2)); rd(1, 1, pat(1)); cyc();
    reset = 1'b1;
    for (int c = 0; c < 4; c++) q[c].delete();
    #1;
    chk("mid-reset b.s1 valid", 32'(ib1.readdatavalid), 32'd0);
    chk("mid-reset b.s1 data", ib1.readdata, 32'd0);
    chk("mid-reset b.s2 valid", 32'(ib2.readdatavalid), 32'd0);
    chk("mid-reset a.s1 valid", 32'(ia1.readdatavalid), 32'd0);
    repeat (2) cyc();
    reset = 1'b0;
    rd(0, 5, 32'hDEADBEAA); rd(1, 7, 32'h22221111); cyc();
    repeat (5) cyc();

    chk("a.s1 drained", 32'(q[0].size()), 32'd0);
    chk("a.s2 drained", 32'(q[1].size()), 32'd0);
    chk("b.s1 drained", 32'(q[2].size()), 32'd0);
    chk("b.s2 drained", 32'(q[3].size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/step_dpram.md
# step_dpram

Parametrised dual-port on-chip RAM for the stepper SoC. Replaces the fixed 32-bit × 51200 single-port RAM with a configurable-width/depth memory that has two independent Avalon-MM slave ports (s1, s2) on one clock. Adds pipelined reads with `readdatavalid`, an optional output register, defined collision priority and out-of-range handling. Sits on the Qsys interconnect as the program/data memory shared by the CPU and the step-profile DMA.

## Interface
Parameters:
- DATA_W, 32, data width in bits; must be a multiple of 8.
- ADDR_W, 16, word-address width.
- DEPTH, 51200, number of words; must be ≤ 2^ADDR_W.
- OUT_REG, 0, 1 adds an output register, so read latency is 2; 0 gives latency 1.
- INIT_FILE, "step_RAM.hex", memory initialisation file.

Ports:
- clk  in  1  single clock for both ports.
- reset  in  1  asynchronous, active-high reset.
- reset_req  in  1  high: stall the whole block (same role as clken low).
- clken  in  1  global clock enable; low: stall.
- sN_address  in  ADDR_W  word address (N = 1, 2).
- sN_chipselect  in  1  port select.
- sN_read  in  1  read strobe.
- sN_write  in  1  write strobe.
- sN_byteenable  in  DATA_W/8  byte lane enables for writes.
- sN_writedata  in  DATA_W  write data.
- sN_readdata  out  DATA_W  read data; valid only when sN_readdatavalid is high.
- sN_readdatavalid  out  1  one-cycle pulse per accepted read.

## Operation
- Accepted request: sN_chipselect high and stall low, where stall = ~clken | reset_req.
- Write: each byte lane i with sN_byteenable[i]=1 is written at sN_address. Lanes with enable 0 are unchanged.
- Read: the word at sN_address is returned L = 1+OUT_REG cycles later, with sN_readdatavalid high for exactly 1 cycle.
- Read and write asserted together on one port: the write executes and the read is dropped (no valid pulse).
- Address ≥ DEPTH:
  - writes are ignored;
  - reads return all-zero data with a normal valid pulse.
- Both ports write the same address in the same cycle: s1 wins for every byte lane that s1 enables. s2 lanes not enabled by s1 are written.
- One port reads while the other writes the same address in the same cycle: the read returns the old data (read-before-write).
- Same-port read of an address written in an earlier cycle returns the new data.
- Stall:
  - requests presented during a stall are ignored (masters must not issue during a stall);
  - the valid/data pipeline freezes and sN_readdatavalid is forced low;
  - the pipeline resumes unchanged once the stall deasserts.
- Memory contents are not affected by reset. Contents after configuration come from INIT_FILE.

## Timing
- Reset values:
  - sN_readdatavalid = 0;
  - sN_readdata = 0;
  - the valid pipeline and the output register are cleared.
- Reset asserted mid-read: in-flight reads are discarded and no valid pulse appears after reset release.
- First request is accepted in the first clock edge after reset deasserts.
- Throughput: 1 request per port per cycle, back-to-back, with no waitrequest.
- OUT_REG=0: data and valid appear in the cycle after the request edge. OUT_REG=1: one cycle later.
- Valid pulses keep request order per port. The two ports are fully independent.

## Structure
- Package step_ram_pkg holds:
  - the BE_W = DATA_W/8 constant;
  - a read-latency function of OUT_REG;
  - a parameter check: DATA_W%8==0 and DEPTH ≤ 2^ADDR_W.
- Sub-module step_ram_port, instanced twice, contains the request decode (accept, range check, read/write qualification) and the valid/zero-flag pipeline.
- Top level holds the inferred true-dual-port array, the byte-lane write logic with s1 priority, and the optional output register.

## Test plan
- Write 0xDEADBEEF to s1 addr 5 with byteenable 0xF, then write 0x000000AA with byteenable 0x1 → s1 read of addr 5 returns 0xDEADBEAA. Check latency 1, then repeat with OUT_REG=1 and check latency 2.
- Same-cycle writes: s1 writes 0x11111111 and s2 writes 0x22222222 to addr 7, both with byteenable 0xF → addr 7 reads 0x11111111. Repeat with s1 byteenable 0x3 → addr 7 reads 0x22221111.
- Cross-port collision: s2 reads addr 9 (holding 0x5) while s1 writes 0x6 to addr 9 → s2 returns 0x5; the next s2 read returns 0x6.
- Out of range: write to addr DEPTH → no change anywhere; read addr DEPTH+3 → 0x00000000 with one valid pulse.
- Back-to-back reads of addrs 0..15 on both ports with clken low for cycles 4-6 → 16 in-order valid pulses per port, none during the stall, data correct.
- Assert reset with 2 reads in flight (OUT_REG=1) → valid and data go to 0 immediately, no pulses after release, and memory contents are preserved.
